// File: rtl/minibus_pkg.sv
// Shared types and constants for the minibus hub: address map entries,
// hub FSM state encoding and default bus widths.
package minibus_pkg;

   localparam int MINIBUS_ADDR_W = 32;
   localparam int MINIBUS_DATA_W = 32;

   // One slave window, half-open [base, limit)
   typedef struct packed {
      logic [MINIBUS_ADDR_W-1:0] base;
      logic [MINIBUS_ADDR_W-1:0] limit;
   } slave_mem_map;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } hub_state_t;

endpackage

// File: rtl/minibus_rr_arbiter.sv
// Round-robin request selector: searches upward from the entry after i_ptr,
// wrapping at N-1, and returns a one-hot grant for the first active request.
module minibus_rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic          o_valid
);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_gnt   = '0;
      o_valid = 1'b0;
      w_idx   = i_ptr;
      for (int k = 0; k < N; k++) begin
         w_idx = (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
         if (!o_valid && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            o_valid      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/minibus_hub.sv
// Multi-master / multi-slave minibus hub: one transaction in flight,
// round-robin master grant, address decode and a busy-cycle abort timer.
//
// state | meaning
// IDLE  | waiting for a request; grant, latch and decode happen here
// BUSY  | selected slave strobed from latches; waiting for s_ready or timeout
// RESP  | one-cycle m_ready pulse to the granted master
module minibus_hub
   import minibus_pkg::*;
#(
   parameter int           MASTER_COUNT = 2,
   parameter int           SLAVE_COUNT  = 2,
   parameter int           ADDR_W       = MINIBUS_ADDR_W,
   parameter int           DATA_W       = MINIBUS_DATA_W,
   parameter slave_mem_map SLAVE_MMAP [SLAVE_COUNT] = '{
      '{base: 32'h0000_0000, limit: 32'h0000_4000},
      '{base: 32'h0000_4000, limit: 32'h0000_4004}},
   parameter int           TIMEOUT      = 255
) (
   input  logic                           clk,
   input  logic                           nrst,
   input  logic [MASTER_COUNT*ADDR_W-1:0] m_addr,
   input  logic [MASTER_COUNT*DATA_W-1:0] m_wdata,
   input  logic [MASTER_COUNT-1:0]        m_ren,
   input  logic [MASTER_COUNT-1:0]        m_wen,
   output logic [MASTER_COUNT*DATA_W-1:0] m_rdata,
   output logic [MASTER_COUNT-1:0]        m_ready,
   output logic [MASTER_COUNT-1:0]        m_error,
   output logic [SLAVE_COUNT*ADDR_W-1:0]  s_addr,
   output logic [SLAVE_COUNT*DATA_W-1:0]  s_wdata,
   output logic [SLAVE_COUNT-1:0]         s_ren,
   output logic [SLAVE_COUNT-1:0]         s_wen,
   input  logic [SLAVE_COUNT*DATA_W-1:0]  s_rdata,
   input  logic [SLAVE_COUNT-1:0]         s_ready
);

   localparam int          MIW        = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
   localparam int          SIW        = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
   localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

   hub_state_t              r_state;
   logic [MIW-1:0]          r_ptr, r_id;
   logic [SIW-1:0]          r_slv;
   logic [ADDR_W-1:0]       r_addr;
   logic [DATA_W-1:0]       r_wdata, r_rdata;
   logic                    r_ren, r_wen, r_err;
   logic [15:0]             r_cnt;
   logic [SLAVE_COUNT-1:0]  r_s_ren, r_s_wen;
   logic [MASTER_COUNT-1:0] r_m_ready;

   logic [MASTER_COUNT-1:0] w_req, w_gnt, w_id_oh;
   logic                    w_gnt_valid;
   logic [MIW-1:0]          w_gnt_id;
   logic [ADDR_W-1:0]       w_req_addr;
   logic [DATA_W-1:0]       w_req_wdata;
   logic                    w_req_ren, w_req_wen;
   logic                    w_hit;
   logic [SIW-1:0]          w_hit_slv;
   logic [SLAVE_COUNT-1:0]  w_hit_oh;
   logic                    w_s_ready;
   logic [DATA_W-1:0]       w_s_rdata;

   assign w_req = m_ren | m_wen;

   minibus_rr_arbiter #(.N(MASTER_COUNT), .IW(MIW)) u_arb (
      .i_req   (w_req),
      .i_ptr   (r_ptr),
      .o_gnt   (w_gnt),
      .o_valid (w_gnt_valid)
   );

   always_comb begin
      w_gnt_id    = '0;
      w_req_addr  = '0;
      w_req_wdata = '0;
      w_req_ren   = 1'b0;
      w_req_wen   = 1'b0;
      w_id_oh     = '0;
      for (int i = 0; i < MASTER_COUNT; i++) begin
         w_id_oh[i] = (r_id == MIW'(i));
         if (w_gnt[i]) begin
            w_gnt_id    = MIW'(i);
            w_req_addr  = m_addr[i*ADDR_W +: ADDR_W];
            w_req_wdata = m_wdata[i*DATA_W +: DATA_W];
            w_req_ren   = m_ren[i];
            w_req_wen   = m_wen[i];
         end
      end
   end

   // Decode the granted address in IDLE so a miss can respond one cycle later;
   // scanning downward lets the lowest matching index win on overlap.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_slv = '0;
      w_hit_oh  = '0;
      for (int j = SLAVE_COUNT-1; j >= 0; j--) begin
         if (w_req_addr >= ADDR_W'(SLAVE_MMAP[j].base) &&
             w_req_addr <  ADDR_W'(SLAVE_MMAP[j].limit)) begin
            w_hit     = 1'b1;
            w_hit_slv = SIW'(j);
         end
      end
      w_hit_oh[w_hit_slv] = w_hit;
   end

   always_comb begin
      w_s_ready = 1'b0;
      w_s_rdata = '0;
      s_addr    = '0;
      s_wdata   = '0;
      for (int j = 0; j < SLAVE_COUNT; j++) begin
         if (r_slv == SIW'(j)) begin
            w_s_ready = s_ready[j];
            w_s_rdata = s_rdata[j*DATA_W +: DATA_W];
            if (r_state == BUSY) begin
               s_addr[j*ADDR_W +: ADDR_W]  = r_addr;
               s_wdata[j*DATA_W +: DATA_W] = r_wdata;
            end
         end
      end
   end

   always_comb begin
      m_rdata = '0;
      m_error = r_m_ready & {MASTER_COUNT{r_err}};
      for (int i = 0; i < MASTER_COUNT; i++) begin
         if (r_m_ready[i]) m_rdata[i*DATA_W +: DATA_W] = r_rdata;
      end
   end

   assign s_ren   = r_s_ren;
   assign s_wen   = r_s_wen;
   assign m_ready = r_m_ready;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state   <= IDLE;
         r_ptr     <= MIW'(MASTER_COUNT-1);
         r_id      <= '0;
         r_slv     <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_ren     <= 1'b0;
         r_wen     <= 1'b0;
         r_err     <= 1'b0;
         r_cnt     <= '0;
         r_s_ren   <= '0;
         r_s_wen   <= '0;
         r_m_ready <= '0;
      end else begin
         r_m_ready <= '0;
         case (r_state)
            IDLE: begin
               if (w_gnt_valid) begin
                  r_id    <= w_gnt_id;
                  r_ptr   <= w_gnt_id;
                  r_addr  <= w_req_addr;
                  r_wdata <= w_req_wdata;
                  r_ren   <= w_req_ren;
                  r_wen   <= w_req_wen;
                  r_slv   <= w_hit_slv;
                  r_cnt   <= '0;
                  if (w_hit && (w_req_ren != w_req_wen)) begin
                     r_state <= BUSY;
                     r_s_ren <= w_req_ren ? w_hit_oh : '0;
                     r_s_wen <= w_req_wen ? w_hit_oh : '0;
                  end else begin
                     r_state   <= RESP;
                     r_err     <= 1'b1;
                     r_rdata   <= '0;
                     r_m_ready <= w_gnt;
                  end
               end
            end
            BUSY: begin
               r_cnt <= r_cnt + 16'd1;
               // s_ready is tested first so it wins a tie with the timeout
               if (w_s_ready) begin
                  r_rdata   <= (r_ren && !r_wen) ? w_s_rdata : '0;
                  r_err     <= 1'b0;
                  r_s_ren   <= '0;
                  r_s_wen   <= '0;
                  r_state   <= RESP;
                  r_m_ready <= w_id_oh;
               end else if (r_cnt + 16'd1 == LP_TIMEOUT) begin
                  r_rdata   <= '0;
                  r_err     <= 1'b1;
                  r_s_ren   <= '0;
                  r_s_wen   <= '0;
                  r_state   <= RESP;
                  r_m_ready <= w_id_oh;
               end
            end
            RESP:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_minibus_hub.sv
// Directed bench for minibus_hub: two masters, two behavioural slaves with
// programmable wait, timeout forced to 4 cycles to keep abort cases short.
module tb_minibus_hub;

   localparam int MC = 2;
   localparam int SC = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic            clk = 1'b0;
   logic            nrst;
   logic [MC*AW-1:0] m_addr;
   logic [MC*DW-1:0] m_wdata;
   logic [MC-1:0]    m_ren, m_wen;
   logic [MC*DW-1:0] m_rdata;
   logic [MC-1:0]    m_ready, m_error;
   logic [SC*AW-1:0] s_addr;
   logic [SC*DW-1:0] s_wdata;
   logic [SC-1:0]    s_ren, s_wen;
   logic [SC*DW-1:0] s_rdata;
   logic [SC-1:0]    s_ready;

   int n_tests = 0;
   int n_fail  = 0;

   int          lat [SC];
   int          sc  [SC] = '{0, 0};
   logic [31:0] wr_seen [SC] = '{32'h0, 32'h0};

   minibus_hub #(
      .MASTER_COUNT (MC),
      .SLAVE_COUNT  (SC),
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .TIMEOUT      (4)
   ) dut (
      .clk     (clk),
      .nrst    (nrst),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_ren   (m_ren),
      .m_wen   (m_wen),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .m_error (m_error),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_ren   (s_ren),
      .s_wen   (s_wen),
      .s_rdata (s_rdata),
      .s_ready (s_ready)
   );

   always #5 clk = ~clk;

   assign s_rdata = {32'hCAFE_0001, 32'hDEAD_BEEF};

   // Slave j answers on the (lat[j]+1)-th consecutive strobe cycle
   always_comb begin
      s_ready = '0;
      for (int j = 0; j < SC; j++)
         s_ready[j] = (s_ren[j] | s_wen[j]) && (sc[j] == lat[j]);
   end

   always @(posedge clk) begin
      for (int j = 0; j < SC; j++) begin
         if (s_ren[j] | s_wen[j]) sc[j] <= sc[j] + 1;
         else                     sc[j] <= 0;
         if (s_wen[j] && s_ready[j]) wr_seen[j] <= s_wdata[j*DW +: DW];
      end
   end

   task automatic clr_req();
      m_ren = '0;
      m_wen = '0;
   endtask

   task automatic drive(input logic m, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d);
      m_ren[m] = rd;
      m_wen[m] = wr;
      if (m) begin m_addr[63:32] = a; m_wdata[63:32] = d; end
      else   begin m_addr[31:0]  = a; m_wdata[31:0]  = d; end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      clr_req();
      m_addr = '0; m_wdata = '0;
      lat[0] = 0; lat[1] = 0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({m_ready, m_error, s_ren, s_wen} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl got %b want 0", {m_ready, m_error, s_ren, s_wen});
      end
      n_tests++;
      if ((m_rdata | s_addr | s_wdata) !== '0) begin
         n_fail++; $display("FAIL reset_data got %h want 0", m_rdata | s_addr | s_wdata);
      end
      nrst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({m_ready, s_ren, s_wen} !== 6'b0) begin
         n_fail++; $display("FAIL reset_idle got %b want 0", {m_ready, s_ren, s_wen});
      end
   endtask

   task automatic test_read();
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      n_tests++;
      if ({s_ren, s_wen, m_ready} !== 6'b01_00_00 || s_addr[31:0] !== 32'h10) begin
         n_fail++; $display("FAIL read_strobe got ren=%b wen=%b rdy=%b addr=%h want 01 00 00 10",
                            s_ren, s_wen, m_ready, s_addr[31:0]);
      end
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b01 || m_error !== 2'b00 || s_ren !== 2'b00) begin
         n_fail++; $display("FAIL read_resp got rdy=%b err=%b ren=%b want 01 00 00", m_ready, m_error, s_ren);
      end
      n_tests++;
      if (m_rdata[31:0] !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL read_data got %h want deadbeef", m_rdata[31:0]);
      end
      clr_req();
      @(negedge clk);
   endtask

   task automatic test_write();
      drive(1'b1, 1'b0, 1'b1, 32'h4000, 32'h1);
      @(negedge clk);
      n_tests++;
      if (s_wen !== 2'b10 || s_ren !== 2'b00 || s_wdata[63:32] !== 32'h1 || s_addr[63:32] !== 32'h4000) begin
         n_fail++; $display("FAIL write_strobe got wen=%b ren=%b wdata=%h addr=%h want 10 00 1 4000",
                            s_wen, s_ren, s_wdata[63:32], s_addr[63:32]);
      end
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b10 || m_error !== 2'b00 || s_wen !== 2'b00) begin
         n_fail++; $display("FAIL write_resp got rdy=%b err=%b wen=%b want 10 00 00", m_ready, m_error, s_wen);
      end
      n_tests++;
      if (wr_seen[1] !== 32'h1 || wr_seen[0] !== 32'h0) begin
         n_fail++; $display("FAIL write_data got s1=%h s0=%h want 1 0", wr_seen[1], wr_seen[0]);
      end
      clr_req();
      @(negedge clk);
   endtask

   task automatic test_errors();
      // miss on master 0
      drive(1'b0, 1'b1, 1'b0, 32'h8000, 32'h0);
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b01 || m_error !== 2'b01 || m_rdata[31:0] !== 32'h0 || (s_ren | s_wen) !== 2'b00) begin
         n_fail++; $display("FAIL miss got rdy=%b err=%b data=%h strobe=%b want 01 01 0 00",
                            m_ready, m_error, m_rdata[31:0], s_ren | s_wen);
      end
      clr_req();
      @(negedge clk);
      // first address past slave 1 window
      drive(1'b1, 1'b1, 1'b0, 32'h4004, 32'h0);
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b10 || m_error !== 2'b10 || (s_ren | s_wen) !== 2'b00) begin
         n_fail++; $display("FAIL limit_miss got rdy=%b err=%b strobe=%b want 10 10 00", m_ready, m_error, s_ren | s_wen);
      end
      clr_req();
      @(negedge clk);
      // read and write together
      drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h5);
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b01 || m_error !== 2'b01 || (s_ren | s_wen) !== 2'b00) begin
         n_fail++; $display("FAIL rw_both got rdy=%b err=%b strobe=%b want 01 01 00", m_ready, m_error, s_ren | s_wen);
      end
      clr_req();
      @(negedge clk);
      // last address inside slave 1 window
      drive(1'b1, 1'b1, 1'b0, 32'h4003, 32'h0);
      @(negedge clk);
      n_tests++;
      if (s_ren !== 2'b10) begin
         n_fail++; $display("FAIL limit_hit_strobe got %b want 10", s_ren);
      end
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b10 || m_error !== 2'b00 || m_rdata[63:32] !== 32'hCAFE_0001) begin
         n_fail++; $display("FAIL limit_hit_resp got rdy=%b err=%b data=%h want 10 00 cafe0001",
                            m_ready, m_error, m_rdata[63:32]);
      end
      clr_req();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      int hi;
      for (int pass = 0; pass < 2; pass++) begin
         lat[0] = (pass == 0) ? 1000 : 3;
         drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
         hi = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_ren === 2'b01 && m_ready === 2'b00) hi++;
         end
         n_tests++;
         if (hi !== 4) begin
            n_fail++; $display("FAIL tmo_strobe_len pass=%0d got %0d want 4", pass, hi);
         end
         @(negedge clk);
         n_tests++;
         if (m_ready !== 2'b01 || s_ren !== 2'b00 || m_error !== ((pass == 0) ? 2'b01 : 2'b00)) begin
            n_fail++; $display("FAIL tmo_resp pass=%0d got rdy=%b ren=%b err=%b want 01 00 %b",
                               pass, m_ready, s_ren, m_error, (pass == 0) ? 2'b01 : 2'b00);
         end
         n_tests++;
         if (m_rdata[31:0] !== ((pass == 0) ? 32'h0 : 32'hDEAD_BEEF)) begin
            n_fail++; $display("FAIL tmo_data pass=%0d got %h want %h",
                               pass, m_rdata[31:0], (pass == 0) ? 32'h0 : 32'hDEAD_BEEF);
         end
         clr_req();
         @(negedge clk);
      end
      lat[0] = 0;
   endtask

   task automatic test_back_to_back();
      logic [1:0]  got  [4];
      logic [31:0] gdat [4];
      logic [1:0]  prev;
      logic [1:0]  exp_g;
      logic [31:0] exp_d;
      int n, pulse_err;
      nrst = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      n = 0; pulse_err = 0; prev = 2'b00;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0);
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         if (m_ready !== 2'b00 && prev !== 2'b00) pulse_err++;
         if (m_ready !== 2'b00) begin
            got[n]  = m_ready;
            gdat[n] = m_ready[1] ? m_rdata[63:32] : m_rdata[31:0];
            n++;
         end
         prev = m_ready;
      end
      clr_req();
      @(negedge clk);
      n_tests++;
      if (n !== 4) begin
         n_fail++; $display("FAIL b2b_count got %0d want 4", n);
      end
      n_tests++;
      if (pulse_err !== 0) begin
         n_fail++; $display("FAIL b2b_pulse got %0d long pulses want 0", pulse_err);
      end
      for (int k = 0; k < n; k++) begin
         exp_g = k[0] ? 2'b10 : 2'b01;
         exp_d = k[0] ? 32'hCAFE_0001 : 32'hDEAD_BEEF;
         n_tests++;
         if (got[k] !== exp_g || gdat[k] !== exp_d) begin
            n_fail++; $display("FAIL b2b_grant%0d got %b/%h want %b/%h", k, got[k], gdat[k], exp_g, exp_d);
         end
      end
   endtask

   task automatic test_reset_mid_busy();
      int bad_rdy;
      lat[1] = 1000;
      drive(1'b1, 1'b1, 1'b0, 32'h4000, 32'h0);
      @(negedge clk);
      n_tests++;
      if (s_ren !== 2'b10) begin
         n_fail++; $display("FAIL rst_busy_pre got %b want 10", s_ren);
      end
      #2 nrst = 1'b0;
      #1;
      n_tests++;
      if (s_ren !== 2'b00 || s_addr !== '0 || m_ready !== 2'b00) begin
         n_fail++; $display("FAIL rst_busy_drop got ren=%b addr=%h rdy=%b want 00 0 00", s_ren, s_addr, m_ready);
      end
      @(negedge clk);
      lat[1] = 0;
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      nrst = 1'b1;
      bad_rdy = 0;
      @(negedge clk);
      if (m_ready[1] !== 1'b0) bad_rdy++;
      n_tests++;
      if (s_ren !== 2'b01) begin
         n_fail++; $display("FAIL rst_regrant got %b want 01", s_ren);
      end
      @(negedge clk);
      n_tests++;
      if (m_ready !== 2'b01 || m_rdata[31:0] !== 32'hDEAD_BEEF || bad_rdy !== 0) begin
         n_fail++; $display("FAIL rst_after_resp got rdy=%b data=%h stray=%0d want 01 deadbeef 0",
                            m_ready, m_rdata[31:0], bad_rdy);
      end
      clr_req();
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_reset_mid_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
